// File: rtl/lrelu_beats_reader.sv
// Purpose : read-side sequencer for the LeakyReLU config store; replays the write beat order
//           (D reg, BRAM_A beats, BRAM_B beats per (clr_i, mtb)) and streams the returned words.
// Latency : first read strobe 1 cycle after an accepted start; data leaves in the cycle memory returns it.
// Backpres: issue is credit-limited to 2 beats outstanding; output held stable until m_ready.
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   start, kw2                : walk request and (kw-1)/2, sampled in IDLE only
//   busy, err, done           : walk in progress, start-rejected pulse, walk-complete pulse
//   r_en, r_sel, clr_i, mtb,
//   r_addr                    : memory read strobe, memory select (1=D,2=A,3=B) and beat coordinates
//   rd_data                   : memory data, valid 1 cycle after r_en
//   m_data, m_valid, m_ready,
//   m_last                    : output beat stream
module lrelu_beats_reader #(
   parameter int MEMBERS     = 8,
   parameter int KW_MAX      = 3,
   parameter int KH_MAX      = 3,
   parameter int BITS_KW2    = 2,
   parameter int BITS_KH     = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int BITS_CLR_I  = $clog2(KW_MAX/2+1),
   // No memory ever holds more than 2 beats for any legal kw2, so the 2-bit floor always applies.
   parameter int BITS_R_ADDR = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [BITS_KW2-1:0]    kw2,
   output logic                   busy,
   output logic                   err,
   output logic                   r_en,
   output logic [1:0]             r_sel,
   output logic [BITS_CLR_I-1:0]  clr_i,
   output logic [BITS_KH-1:0]     mtb,
   output logic [BITS_R_ADDR-1:0] r_addr,
   input  logic [DATA_WIDTH-1:0]  rd_data,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   m_last,
   output logic                   done
);

   localparam int KW2_MAX = KW_MAX / 2;
   localparam int LUT_N   = 1 << BITS_CLR_I;
   // Highest BRAM_B row that can exist; 2*clr_i never exceeds it for a sane configuration.
   localparam int MTB_MAX = (KH_MAX - 1 < KW_MAX - 1) ? KH_MAX - 1 : KW_MAX - 1;

   typedef enum logic [2:0] {IDLE, S_REG_D, S_BRAM_A, S_BRAM_B, DRAIN} state_t;

   // ceil(2 / kw)
   function automatic int a_beats_f(input int k2);
      int kw;
      kw = 2 * k2 + 1;
      return (2 + kw - 1) / kw;
   endfunction

   // ceil(2*(MEMBERS/kw) / (MEMBERS/(2*clr+1))), never below one beat
   function automatic int b_beats_f(input int k2, input int c);
      int kw, num, den, res;
      kw  = 2 * k2 + 1;
      num = 2 * (MEMBERS / kw);
      den = MEMBERS / (2 * c + 1);
      if (den < 1) den = 1;
      res = (num + den - 1) / den;
      if (res < 1) res = 1;
      return res;
   endfunction

   // Last-address tables, fixed at elaboration and indexed by the latched kw2 (and clr_i).
   logic [BITS_R_ADDR-1:0] a_last_lut [LUT_N];
   logic [BITS_R_ADDR-1:0] b_last_lut [LUT_N][LUT_N];

   for (genvar gk = 0; gk < LUT_N; gk++) begin : g_lut_k
      assign a_last_lut[gk] = BITS_R_ADDR'(a_beats_f(gk) - 1);
      for (genvar gc = 0; gc < LUT_N; gc++) begin : g_lut_c
         assign b_last_lut[gk][gc] = BITS_R_ADDR'(b_beats_f(gk, gc) - 1);
      end
   end

   state_t                 state_q;
   logic [BITS_CLR_I-1:0]  kw2_q;
   logic [BITS_CLR_I-1:0]  clr_q;
   logic [BITS_KH-1:0]     mtb_q;
   logic [BITS_R_ADDR-1:0] addr_q;
   logic                   err_q;
   logic                   done_q;

   // Return path: one read in flight plus a 2-entry FIFO of {last, data}.
   logic                   inf_q;
   logic                   inf_last_q;
   logic [DATA_WIDTH:0]    fifo_q [2];
   logic                   wr_ptr_q;
   logic                   rd_ptr_q;
   logic [1:0]             cnt_q;
   logic [1:0]             cnt_d;

   logic                   issuing;
   logic                   credit_ok;
   logic [BITS_KH-1:0]     mtb_top;
   logic                   a_wrap;
   logic                   b_wrap;
   logic                   mtb_wrap;
   logic                   clr_wrap;
   logic                   final_beat;
   logic                   hs;
   logic                   push;
   logic                   pop;

   assign issuing   = (state_q == S_REG_D) || (state_q == S_BRAM_A) || (state_q == S_BRAM_B);
   // Everything issued but not yet accepted must fit in the FIFO.
   assign credit_ok = (2'(inf_q) + cnt_q) < 2'd2;
   assign r_en      = issuing && credit_ok;

   always_comb begin
      r_sel = 2'd0;
      if (r_en) begin
         case (state_q)
            S_REG_D:  r_sel = 2'd1;
            S_BRAM_A: r_sel = 2'd2;
            S_BRAM_B: r_sel = 2'd3;
            default:  r_sel = 2'd0;
         endcase
      end
   end

   always_comb begin
      mtb_top = BITS_KH'(2 * int'(clr_q));
      if (2 * int'(clr_q) > MTB_MAX) mtb_top = BITS_KH'(MTB_MAX);
   end

   assign a_wrap     = (addr_q == a_last_lut[kw2_q]);
   assign b_wrap     = (addr_q == b_last_lut[kw2_q][clr_q]);
   assign mtb_wrap   = (mtb_q == mtb_top);
   assign clr_wrap   = (clr_q == kw2_q);
   assign final_beat = (state_q == S_BRAM_B) && b_wrap && mtb_wrap && clr_wrap;

   // Head of FIFO has priority; with an empty FIFO the returning word is shown directly.
   assign m_valid = inf_q || (cnt_q != 2'd0);

   always_comb begin
      m_data = '0;
      m_last = 1'b0;
      if (cnt_q != 2'd0) begin
         {m_last, m_data} = fifo_q[rd_ptr_q];
      end else if (inf_q) begin
         {m_last, m_data} = {inf_last_q, rd_data};
      end
   end

   assign hs    = m_valid && m_ready;
   assign pop   = (cnt_q != 2'd0) && m_ready;
   // A returning word is parked unless it bypasses straight out to the consumer.
   assign push  = inf_q && ((cnt_q != 2'd0) || !m_ready);
   assign cnt_d = cnt_q + 2'(push) - 2'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         kw2_q   <= '0;
         clr_q   <= '0;
         mtb_q   <= '0;
         addr_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         err_q  <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (int'(kw2) > KW2_MAX) begin
                     err_q <= 1'b1;
                  end else begin
                     kw2_q   <= BITS_CLR_I'(kw2);
                     clr_q   <= '0;
                     mtb_q   <= '0;
                     addr_q  <= '0;
                     state_q <= S_REG_D;
                  end
               end
            end
            S_REG_D: begin
               if (r_en) state_q <= S_BRAM_A;
            end
            S_BRAM_A: begin
               if (r_en) begin
                  if (a_wrap) begin
                     addr_q  <= '0;
                     state_q <= S_BRAM_B;
                  end else begin
                     addr_q <= addr_q + BITS_R_ADDR'(1);
                  end
               end
            end
            S_BRAM_B: begin
               if (r_en) begin
                  if (b_wrap) begin
                     addr_q <= '0;
                     if (mtb_wrap) begin
                        mtb_q <= '0;
                        if (clr_wrap) state_q <= DRAIN;
                        else          clr_q   <= clr_q + BITS_CLR_I'(1);
                     end else begin
                        mtb_q <= mtb_q + BITS_KH'(1);
                     end
                  end else begin
                     addr_q <= addr_q + BITS_R_ADDR'(1);
                  end
               end
            end
            DRAIN: begin
               // The tagged beat is always the youngest, so its handshake empties the path.
               if (hs && m_last) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inf_q      <= 1'b0;
         inf_last_q <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         cnt_q      <= 2'd0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
      end else begin
         inf_q      <= r_en;
         inf_last_q <= r_en && final_beat;
         if (push) begin
            fifo_q[wr_ptr_q] <= {inf_last_q, rd_data};
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign err    = err_q;
   assign done   = done_q;
   assign clr_i  = clr_q;
   assign mtb    = mtb_q;
   assign r_addr = addr_q;

endmodule

// File: tb/tb_lrelu_beats_reader.sv
// Bench for lrelu_beats_reader with MEMBERS=8, KW_MAX=3: directed walks for kw2=0 and kw2=1,
// backpressure, rejected start, mid-walk reset and ignored restart.
// Memory model returns a word keyed by (sel, clr, mtb, addr) one cycle after r_en.
module tb_lrelu_beats_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  kw2;
   logic        busy, err, r_en, m_valid, m_ready, m_last, done;
   logic [1:0]  r_sel;
   logic [0:0]  clr_i;
   logic [1:0]  mtb;
   logic [1:0]  r_addr;
   logic [31:0] rd_data;
   logic [31:0] m_data;

   int n_checks = 0;
   int n_errors = 0;

   // Expected issue order as {sel, clr, mtb, addr} nibbles, worked out by hand.
   logic [15:0] tbl0 [5] = '{16'h1000, 16'h2000, 16'h2001, 16'h3000, 16'h3001};
   logic [15:0] tbl1 [9] = '{16'h1000, 16'h2000, 16'h3000, 16'h3100, 16'h3101,
                             16'h3110, 16'h3111, 16'h3120, 16'h3121};
   bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   always #5 clk = ~clk;

   lrelu_beats_reader #(
      .MEMBERS(8), .KW_MAX(3), .KH_MAX(3), .BITS_KW2(2), .BITS_KH(2), .DATA_WIDTH(32)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .kw2(kw2), .busy(busy), .err(err),
      .r_en(r_en), .r_sel(r_sel), .clr_i(clr_i), .mtb(mtb), .r_addr(r_addr),
      .rd_data(rd_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .done(done)
   );

   function automatic logic [31:0] tup(logic [1:0] s, logic [0:0] c, logic [1:0] m, logic [1:0] a);
      return {16'h0, 2'b0, s, 3'b0, c, 2'b0, m, 2'b0, a};
   endfunction

   function automatic logic [31:0] exp_tup(int k, int i);
      if (k == 0) return {16'h0, tbl0[i]};
      return {16'h0, tbl1[i]};
   endfunction

   // Registered memory; junk on idle cycles must never reach the output.
   always @(posedge clk) begin
      if (r_en) rd_data <= 32'hC0DE0000 | tup(r_sel, clr_i, mtb, r_addr);
      else      rd_data <= 32'hBAD00000 | 32'($urandom_range(0, 65535));
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_err"},   err, 0);
      chk({tag, "_ren"},   r_en, 0);
      chk({tag, "_valid"}, m_valid, 0);
      chk({tag, "_last"},  m_last, 0);
      chk({tag, "_done"},  done, 0);
      chk({tag, "_coord"}, tup(r_sel, clr_i, mtb, r_addr), 0);
      chk({tag, "_data"},  m_data, 0);
   endtask

   // mode 0: m_ready high, 1: m_ready toggles 1,0,0,1, 2: m_ready high plus a restart attempt.
   task automatic run_walk(input int k, input int nb, input int mode);
      int iss = 0, acc = 0, last_cyc = -1, done_cyc = -1, first_v = -1;
      bit stalled = 1'b0;
      logic [31:0] pdat = '0;
      logic plast = 1'b0;
      @(negedge clk);
      start = 1'b1; kw2 = 2'(k); m_ready = 1'b1;
      for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         if (cyc == 1) start = 1'b0;
         if (mode == 2) begin
            if (cyc == 3) begin start = 1'b1; kw2 = 2'd0; end
            else if (cyc == 4) begin start = 1'b0; kw2 = 2'd2; end
         end
         m_ready = (mode == 1) ? rdy_pat[(cyc - 1) % 4] : 1'b1;
         #1;
         if (cyc == 1) chk("busy_rise", busy, 1);
         if (mode == 2 && (cyc == 4 || cyc == 5)) chk("restart_no_err", err, 0);
         if (r_en) begin
            chk("credit", 32'((iss - acc) < 2), 1);
            if (iss < nb) chk("issue_tuple", tup(r_sel, clr_i, mtb, r_addr), exp_tup(k, iss));
            else          chk("extra_issue", iss, nb - 1);
            iss++;
         end
         if (m_valid && first_v < 0) first_v = cyc;
         if (stalled) begin
            chk("stable_data", m_data, pdat);
            chk("stable_last", m_last, plast);
         end
         if (m_valid && m_ready) begin
            if (acc < nb) begin
               chk("out_data", m_data, 32'hC0DE0000 | exp_tup(k, acc));
               chk("out_last", m_last, 32'(acc == nb - 1));
            end
            acc++;
            if (m_last) last_cyc = cyc;
         end
         stalled = m_valid && !m_ready;
         pdat    = m_data;
         plast   = m_last;
         if (done) begin
            done_cyc = cyc;
            chk("busy_fall", busy, 0);
         end
      end
      chk("issued", iss, nb);
      chk("accepted", acc, nb);
      chk("first_valid", first_v, 2);
      chk("done_after_last", done_cyc, last_cyc + 1);
      if (mode == 0) chk("done_cycle", done_cyc, nb + 2);
      kw2 = 2'd0;
      @(negedge clk);
      #1;
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      bit saw_done, saw_ren;
      rst = 1'b1; start = 1'b0; kw2 = 2'd0; m_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk_idle("reset");
      rst = 1'b0;

      run_walk(0, 5, 0);
      run_walk(1, 9, 0);
      run_walk(1, 9, 1);

      // Out-of-range kw2 is rejected with a single err pulse.
      @(negedge clk);
      start = 1'b1; kw2 = 2'd2;
      @(negedge clk);
      start = 1'b0; kw2 = 2'd0;
      #1;
      chk("reject_err", err, 1);
      chk("reject_busy", busy, 0);
      chk("reject_ren", r_en, 0);
      @(negedge clk);
      #1;
      chk("reject_err_pulse", err, 0);
      chk("reject_busy2", busy, 0);

      // Reset 3 cycles into a walk aborts it without done.
      @(negedge clk);
      start = 1'b1; kw2 = 2'd1; m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk_idle("abort");
      rst = 1'b0;
      saw_done = 1'b0; saw_ren = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         if (done) saw_done = 1'b1;
         if (r_en) saw_ren = 1'b1;
      end
      chk("abort_no_done", saw_done, 0);
      chk("abort_no_ren", saw_ren, 0);

      run_walk(1, 9, 0);
      run_walk(1, 9, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
